// File: rtl/lj_rx_lite_if.sv
// Left Justified receiver bus: external serial lines and enable in, parallel samples and status out.
interface lj_rx_lite_if #(
  parameter int unsigned dataW = 12
);
  logic             BCLK;
  logic             LRCLK;
  logic             SDATA;
  logic             enable;
  logic [dataW-1:0] dataR;
  logic [dataW-1:0] dataL;
  logic             valid;
  logic             busy;
  logic             frame_err;

  modport master (
    output BCLK, LRCLK, SDATA, enable,
    input  dataR, dataL, valid, busy, frame_err
  );

  modport slave (
    input  BCLK, LRCLK, SDATA, enable,
    output dataR, dataL, valid, busy, frame_err
  );
endinterface

// File: rtl/lj_rx_lite.sv
// Slave-mode Left Justified serial audio receiver: oversamples BCLK/LRCLK/SDATA on clk, emits R/L pairs.
// Optional short-channel detection is enabled by defining LJ_RX_FRAME_ERR_EN.
module lj_rx_lite #(
  parameter int unsigned dataW = 12
) (
  input  logic         clk,
  input  logic         rst,
  lj_rx_lite_if.slave  bus
);
  localparam int unsigned     CntW   = $clog2(dataW + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(dataW);
  localparam logic [dataW-1:0] Msb   = {1'b1, {(dataW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SYNC, RIGHTCH, LEFTCH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bclk_q, bclk_d;
  logic [1:0]       lrclk_q, lrclk_d;
  logic [1:0]       sdata_q, sdata_d;
  logic             lr_prev_q, lr_prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [dataW-1:0] shift_r_q, shift_r_d;
  logic [dataW-1:0] shift_l_q, shift_l_d;
  logic [dataW-1:0] data_r_q, data_r_d;
  logic [dataW-1:0] data_l_q, data_l_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
`ifdef LJ_RX_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  logic             bit_ev, boundary, bit_s, lr_s, cnt_full;
  logic             go_right, go_left;
  logic [dataW-1:0] bit_mask;

  // Next-state, datapath and output logic.
  always_comb begin
    bclk_d    = {bclk_q[1:0], bus.BCLK};
    lrclk_d   = {lrclk_q[0], bus.LRCLK};
    sdata_d   = {sdata_q[0], bus.SDATA};
    bit_ev    = bclk_q[1] & ~bclk_q[2];
    bit_s     = sdata_q[1];
    lr_s      = lrclk_q[1];
    boundary  = bit_ev && (lr_s != lr_prev_q);
    cnt_full  = (cnt_q == CntMax);
    // Bits land at position dataW-1-cnt, so a short channel is naturally zero-filled.
    bit_mask  = bit_s ? (Msb >> cnt_q) : '0;

    state_d   = state_q;
    lr_prev_d = bit_ev ? lr_s : lr_prev_q;
    cnt_d     = cnt_q;
    shift_r_d = shift_r_q;
    shift_l_d = shift_l_q;
    data_r_d  = data_r_q;
    data_l_d  = data_l_q;
    valid_d   = 1'b0;
    go_right  = 1'b0;
    go_left   = 1'b0;
`ifdef LJ_RX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: state_d = SYNC;
      SYNC: begin
        if (boundary && !lr_s) go_right = 1'b1;
      end
      RIGHTCH, LEFTCH: begin
        if (boundary) begin
`ifdef LJ_RX_FRAME_ERR_EN
          if (!cnt_full) begin
            frame_err_d = 1'b1;
            if (lr_s) state_d = SYNC;
            else      go_right = 1'b1;
          end else if (lr_s) begin
            go_left = 1'b1;
          end else begin
            go_right = 1'b1;
          end
`else
          // A short left channel is delivered when the next frame starts.
          if (!lr_s && (state_q == LEFTCH) && !cnt_full) begin
            data_r_d = shift_r_q;
            data_l_d = shift_l_q;
            valid_d  = 1'b1;
          end
          if (lr_s) go_left = 1'b1;
          else      go_right = 1'b1;
`endif
        end else if (bit_ev && !cnt_full) begin
          cnt_d = cnt_q + CntW'(1);
          if (state_q == RIGHTCH) begin
            shift_r_d = shift_r_q | bit_mask;
          end else begin
            shift_l_d = shift_l_q | bit_mask;
            if (cnt_d == CntMax) begin
              data_r_d = shift_r_q;
              data_l_d = shift_l_d;
              valid_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_right) begin
      state_d   = RIGHTCH;
      cnt_d     = CntW'(1);
      shift_r_d = bit_s ? Msb : '0;
      shift_l_d = '0;
    end
    if (go_left) begin
      state_d   = LEFTCH;
      cnt_d     = CntW'(1);
      shift_l_d = bit_s ? Msb : '0;
    end

    // Dropping enable abandons any partial frame and keeps the last delivered samples.
    if (!bus.enable) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      data_r_d = data_r_q;
      data_l_d = data_l_q;
`ifdef LJ_RX_FRAME_ERR_EN
      frame_err_d = 1'b0;
`endif
    end

    busy_d = (state_d == RIGHTCH) || (state_d == LEFTCH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bclk_q    <= '0;
      lrclk_q   <= '0;
      sdata_q   <= '0;
      lr_prev_q <= 1'b0;
      cnt_q     <= '0;
      shift_r_q <= '0;
      shift_l_q <= '0;
      data_r_q  <= '0;
      data_l_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LJ_RX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      lr_prev_q <= lr_prev_d;
      cnt_q     <= cnt_d;
      shift_r_q <= shift_r_d;
      shift_l_q <= shift_l_d;
      data_r_q  <= data_r_d;
      data_l_q  <= data_l_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef LJ_RX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign bus.dataR = data_r_q;
  assign bus.dataL = data_l_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
`ifdef LJ_RX_FRAME_ERR_EN
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_lj_rx_lite.sv
// Scoreboard bench for lj_rx_lite: directed LJ frames in, expected sample pairs checked by a monitor.
module tb_lj_rx_lite;
  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  lj_rx_lite_if #(.dataW(W)) bus ();
  lj_rx_lite #(.dataW(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ferr_exp = 0;
  int   mark_cyc = -1;
  int   abort_cyc = -1;
  int   rst_cyc = -1;
  int   busy_drop = 0;
  bit   prev_valid = 1'b0;
  bit   chk_busy_hi = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every valid and checks timed events.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid) begin
      chk("valid_single", 32'(prev_valid), 32'd0);
      chk("valid_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dataR", 32'(bus.dataR), 32'(e.r));
        chk("dataL", 32'(bus.dataL), 32'(e.l));
        chk("valid_latency", 32'(cyc), 32'(mark_cyc));
      end
    end
    if (bus.frame_err) begin
      chk("frame_err_expected", 32'(ferr_exp > 0), 32'd1);
      if (ferr_exp > 0) ferr_exp--;
    end
    if (chk_busy_hi && !bus.busy) busy_drop++;
    if (cyc == abort_cyc) begin
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_valid", 32'(bus.valid), 32'd0);
      chk("abort_hold_R", 32'(bus.dataR), 32'h123);
      chk("abort_hold_L", 32'(bus.dataL), 32'h456);
    end
    if (cyc == rst_cyc) begin
      chk("rst_dataR", 32'(bus.dataR), 32'd0);
      chk("rst_dataL", 32'(bus.dataL), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    end
    prev_valid = bus.valid;
  end

  // One channel: data changes on BCLK fall, 5 clk low then 5 clk high per bit.
  // act_kind: 1 = drop enable, 2 = raise enable, 3 = one-cycle reset pulse.
  task automatic send_channel(input logic lr, input logic [W-1:0] w, input int nbits,
                              input int nbclk, input int mark, input int act_bit,
                              input int act_kind);
    for (int i = 0; i < nbclk; i++) begin
      bus.BCLK  = 1'b0;
      bus.LRCLK = lr;
      bus.SDATA = (i < nbits) ? w[W-1-i] : 1'b0;
      if (i == act_bit) begin
        case (act_kind)
          1: begin bus.enable = 1'b0; abort_cyc = cyc + 1; end
          2: bus.enable = 1'b1;
          3: begin rst = 1'b0; rst_cyc = cyc + 1; end
          default: ;
        endcase
      end
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (j == 0) rst = 1'b1;
      end
      bus.BCLK = 1'b1;
      if (i == mark) mark_cyc = cyc + 3;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] r, input logic [W-1:0] l, input int nr,
                            input int nbr, input int ract_bit, input int ract_kind,
                            input int lact_bit, input int lact_kind);
    send_channel(1'b0, r, nr, nbr, -1, ract_bit, ract_kind);
    send_channel(1'b1, l, W, 16, W - 1, lact_bit, lact_kind);
  endtask

  initial begin
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.BCLK = 1'b0;
    bus.LRCLK = 1'b0;
    bus.SDATA = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dataR", 32'(bus.dataR), 32'd0);
    chk("reset_dataL", 32'(bus.dataL), 32'd0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b1;
    bus.enable = 1'b1;

    // Lead-in left channel so the first right channel starts on an LRCLK fall.
    send_channel(1'b1, '0, 0, 16, -1, -1, 0);

    q.push_back('{12'hA5C, 12'h3F1});
    send_frame(12'hA5C, 12'h3F1, W, 16, -1, 0, -1, 0);

    chk_busy_hi = 1'b1;
    q.push_back('{12'h001, 12'hFFF});
    send_frame(12'h001, 12'hFFF, W, 16, -1, 0, -1, 0);
    q.push_back('{12'h800, 12'h7FF});
    send_frame(12'h800, 12'h7FF, W, 16, -1, 0, -1, 0);
    chk_busy_hi = 1'b0;

`ifdef LJ_RX_FRAME_ERR_EN
    ferr_exp = 1;
`else
    q.push_back('{12'hA50, 12'h3F1});
`endif
    send_frame(12'hA5C, 12'h3F1, 8, 8, -1, 0, -1, 0);
    q.push_back('{12'h123, 12'h456});
    send_frame(12'h123, 12'h456, W, 16, -1, 0, -1, 0);

    // Abort after 5 left bits; nothing delivered, previous samples held.
    send_frame(12'h0F0, 12'h0F0, W, 16, -1, 0, 5, 1);

    // Enable returns mid-left; only the following full frame is delivered.
    send_frame(12'hABC, 12'hDEF, W, 16, -1, 0, 6, 2);
    q.push_back('{12'h5A5, 12'hA5A});
    send_frame(12'h5A5, 12'hA5A, W, 16, -1, 0, -1, 0);

    // Reset pulse mid-right; receiver must resync on the next LRCLK fall.
    send_frame(12'h777, 12'h777, W, 16, 4, 3, -1, 0);
    q.push_back('{12'h3C3, 12'hC3C});
    send_frame(12'h3C3, 12'hC3C, W, 16, -1, 0, -1, 0);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("frame_err_pending", 32'(ferr_exp), 32'd0);
    chk("busy_between_frames", 32'(busy_drop), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
